// File: rtl/avmm_dp_onchip_ram.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports sharing one clock.
// It has byte-lane writes, a 1- or 2-stage read pipeline and a built-in zero-fill engine.
module avmm_dp_onchip_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic                    clear_req,
  output logic                    clear_busy,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t                  state_r, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt_r, cnt_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    en_s;
  logic                    wait_s;
  logic                    clr_wr_s;
  logic                    wr1_s, rd1_s, wr2_s, rd2_s;

  logic [DATA_WIDTH-1:0]   s1_q1_r, s2_q1_r;
  logic                    s1_v1_r, s2_v1_r;

  assign en_s     = clken & ~reset_req;
  assign wait_s   = reset | (state_r == ST_CLEAR) | ~en_s;
  assign clr_wr_s = (state_r == ST_CLEAR) & en_s & ~reset;

  // A simultaneous read+write on one port is treated as a write only.
  assign wr1_s = s1_chipselect & s1_write & ~wait_s;
  assign rd1_s = s1_chipselect & s1_read & ~s1_write & ~wait_s;
  assign wr2_s = s2_chipselect & s2_write & ~wait_s;
  assign rd2_s = s2_chipselect & s2_read & ~s2_write & ~wait_s;

  assign s1_waitrequest = wait_s;
  assign s2_waitrequest = wait_s;
  assign clear_busy     = (state_r == ST_CLEAR) & ~reset;

  // State and clear-counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RST_STATE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Next-state logic: the clear walks every address once, then returns to READY
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (en_s) begin
          if (cnt_r == {ADDR_WIDTH{1'b1}}) begin
            state_nxt = ST_READY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt_r + ADDR_WIDTH'(1);
          end
        end else begin
          cnt_nxt   = cnt_r;
        end
      end
      ST_READY: begin
        if (en_s && clear_req) begin
          state_nxt = ST_CLEAR;
        end else begin
          state_nxt = ST_READY;
        end
      end
      default: begin
        state_nxt = ST_READY;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Array write: s1 is applied last so it owns any lane both ports enable
  always_ff @(posedge clk) begin
    if (clr_wr_s) begin
      mem[cnt_r] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wr2_s && s2_byteenable[b]) begin
          mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
        end
        if (wr1_s && s1_byteenable[b]) begin
          mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
        end
      end
    end
  end

  // First read stage; sampling before the write lands gives old-data semantics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q1_r <= '0;
      s1_v1_r <= 1'b0;
      s2_q1_r <= '0;
      s2_v1_r <= 1'b0;
    end else if (en_s) begin
      s1_v1_r <= rd1_s;
      s2_v1_r <= rd2_s;
      if (rd1_s) begin
        s1_q1_r <= mem[s1_address];
      end
      if (rd2_s) begin
        s2_q1_r <= mem[s2_address];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_q2_r, s2_q2_r;
      logic                  s1_v2_r, s2_v2_r;

      // Optional output register stage
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_q2_r <= '0;
          s1_v2_r <= 1'b0;
          s2_q2_r <= '0;
          s2_v2_r <= 1'b0;
        end else if (en_s) begin
          s1_v2_r <= s1_v1_r;
          s2_v2_r <= s2_v1_r;
          if (s1_v1_r) begin
            s1_q2_r <= s1_q1_r;
          end
          if (s2_v1_r) begin
            s2_q2_r <= s2_q1_r;
          end
        end
      end

      assign s1_readdata      = s1_q2_r;
      assign s1_readdatavalid = s1_v2_r;
      assign s2_readdata      = s2_q2_r;
      assign s2_readdatavalid = s2_v2_r;
    end else begin : g_lat1
      assign s1_readdata      = s1_q1_r;
      assign s1_readdatavalid = s1_v1_r;
      assign s2_readdata      = s2_q1_r;
      assign s2_readdatavalid = s2_v1_r;
    end
  endgenerate

endmodule

// File: tb/tb_avmm_dp_onchip_ram.sv
// Directed self-checking bench for avmm_dp_onchip_ram (32-bit x 16 words, read latency 2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_avmm_dp_onchip_ram;

  logic        clk = 1'b0;
  logic        reset, reset_req, clken, clear_req;
  logic        clear_busy;
  logic [3:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;
  logic [31:0] s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid;
  logic        s1_waitrequest, s2_waitrequest;

  int n_checks = 0;
  int n_pass   = 0;

  int          busy_n, vld_n;
  logic        wr_ok;
  logic [31:0] vld_data;

  always #5 clk = ~clk;

  avmm_dp_onchip_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rdata(input int p);
    return (p == 1) ? s1_readdata : s2_readdata;
  endfunction

  function automatic logic rdv(input int p);
    return (p == 1) ? s1_readdatavalid : s2_readdatavalid;
  endfunction

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s1_address = 4'h0; s1_byteenable = 4'h0; s1_writedata = 32'h0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    s2_address = 4'h0; s2_byteenable = 4'h0; s2_writedata = 32'h0;
  endtask

  task automatic drive(input int p, input logic rd, input logic wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (p == 1) begin
      s1_chipselect = 1'b1; s1_read = rd; s1_write = wr;
      s1_address = a; s1_writedata = d; s1_byteenable = be;
    end else begin
      s2_chipselect = 1'b1; s2_read = rd; s2_write = wr;
      s2_address = a; s2_writedata = d; s2_byteenable = be;
    end
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(p, 1'b0, 1'b1, a, d, be);
    @(negedge clk);
    idle();
  endtask

  // Valid must be low one cycle after acceptance and high on the second.
  task automatic rd_check(input int p, input logic [3:0] a, input logic [31:0] exp, input string tag);
    drive(p, 1'b1, 1'b0, a, 32'h0, 4'h0);
    @(negedge clk);
    idle();
    check({tag, "_lat1"}, {31'd0, rdv(p)}, 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, {31'd0, rdv(p)}, 32'd1);
    check(tag, rdata(p), exp);
  endtask

  task automatic count_busy(output int n, output logic ok, output int vn, output logic [31:0] vd);
    n = 0; ok = 1'b1; vn = 0; vd = 32'h0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (s2_readdatavalid) begin
        vn++;
        vd = s2_readdata;
      end
      if (!clear_busy) break;
      n++;
      if (!(s1_waitrequest && s2_waitrequest)) ok = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1; clear_req = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    check("rst_rdata1", s1_readdata, 32'h0);
    check("rst_rdata2", s2_readdata, 32'h0);
    check("rst_vld", {30'd0, s1_readdatavalid, s2_readdatavalid}, 32'd0);
    check("rst_wait", {30'd0, s1_waitrequest, s2_waitrequest}, 32'd3);
    check("rst_busy", {31'd0, clear_busy}, 32'd0);

    reset = 1'b0;
    count_busy(busy_n, wr_ok, vld_n, vld_data);
    check("boot_busy_cycles", busy_n, 32'd16);
    check("boot_wait_high", {31'd0, wr_ok}, 32'd1);
    for (int i = 0; i < 16; i++) rd_check(1, 4'(i), 32'h0, $sformatf("boot_zero_a%0d", i));

    // Byte-lane merge
    wr(1, 4'd3, 32'hDEADBEEF, 4'b1111);
    wr(1, 4'd3, 32'h11223344, 4'b0101);
    @(negedge clk);
    check("wr_no_vld", {30'd0, s1_readdatavalid, s2_readdatavalid}, 32'd0);
    rd_check(2, 4'd3, 32'hDE22BE44, "be_merge");

    // Write on s1 with read on s2, same address: read sees old data
    drive(1, 1'b0, 1'b1, 4'd3, 32'hCAFEF00D, 4'b1111);
    drive(2, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("rdw_old", s2_readdata, 32'hDE22BE44);
    rd_check(2, 4'd3, 32'hCAFEF00D, "rdw_new");

    // Dual write to the same word: s1 owns overlapping lane 1
    drive(1, 1'b0, 1'b1, 4'd5, 32'hAAAAAAAA, 4'b0011);
    drive(2, 1'b0, 1'b1, 4'd5, 32'hBBBBBBBB, 4'b0110);
    @(negedge clk);
    idle();
    drive(1, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    drive(2, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("ww_s1", s1_readdata, 32'h00BBAAAA);
    check("ww_s2", s2_readdata, 32'h00BBAAAA);

    // Streaming with a two-cycle clken stall
    for (int i = 0; i < 4; i++) wr(1, 4'(i), 32'h10 + 32'(i), 4'b1111);
    drive(1, 1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    @(negedge clk);
    check("strm0", {s1_readdatavalid, s1_readdata[30:0]}, 32'h80000010);
    clken = 1'b0;
    drive(1, 1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    #1;
    check("strm_wait", {30'd0, s1_waitrequest, s2_waitrequest}, 32'd3);
    @(negedge clk);
    check("strm_hold_a", {s1_readdatavalid, s1_readdata[30:0]}, 32'h80000010);
    @(negedge clk);
    check("strm_hold_b", {s1_readdatavalid, s1_readdata[30:0]}, 32'h80000010);
    clken = 1'b1;
    @(negedge clk);
    check("strm1", {s1_readdatavalid, s1_readdata[30:0]}, 32'h80000011);
    drive(1, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    @(negedge clk);
    check("strm2", {s1_readdatavalid, s1_readdata[30:0]}, 32'h80000012);
    idle();
    @(negedge clk);
    check("strm3", {s1_readdatavalid, s1_readdata[30:0]}, 32'h80000013);
    @(negedge clk);
    check("strm_end", {31'd0, s1_readdatavalid}, 32'd0);
    reset_req = 1'b1;
    #1;
    check("rreq_wait", {31'd0, s1_waitrequest}, 32'd1);
    reset_req = 1'b0;

    // clear_req coinciding with an accepted read
    wr(1, 4'd7, 32'h77, 4'b1111);
    drive(2, 1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    clear_req = 1'b1;
    @(negedge clk);
    idle();
    clear_req = 1'b0;
    count_busy(busy_n, wr_ok, vld_n, vld_data);
    check("clr_busy_cycles", busy_n, 32'd16);
    check("clr_wait_high", {31'd0, wr_ok}, 32'd1);
    check("clr_rd_pulses", vld_n, 32'd1);
    check("clr_rd_old", vld_data, 32'h77);
    rd_check(2, 4'd7, 32'h0, "clr_a7");

    // Reset while the clear counter sits at 9
    wr(1, 4'd9, 32'h99, 4'b1111);
    rd_check(1, 4'd9, 32'h99, "pre_rst_a9");
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", {31'd0, clear_busy}, 32'd1);
    check("mid_hold", s1_readdata, 32'h99);
    reset = 1'b1;
    #1;
    check("mid_rst_rdata", s1_readdata, 32'h0);
    check("mid_rst_busy", {31'd0, clear_busy}, 32'd0);
    check("mid_rst_wait", {30'd0, s1_waitrequest, s2_waitrequest}, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    count_busy(busy_n, wr_ok, vld_n, vld_data);
    check("restart_busy_cycles", busy_n, 32'd16);
    check("restart_wait_high", {31'd0, wr_ok}, 32'd1);
    rd_check(1, 4'd9, 32'h0, "restart_a9");
    rd_check(2, 4'd15, 32'h0, "restart_a15");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
